trade_tape: RTL and testbench
=============================

Name: trade_tape

Overview:
- Downstream consumer of the order book's match output.
- Captures every match event (match_valid / match_price) into a timestamped FIFO.
- Presents the FIFO contents to the readout/UART stage over a valid/ready interface.
- Maintains running trade statistics (last price, signed price delta, trade count, drops) for the risk/ML and circuit-breaker logic.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16.
- TS_W, 16, timestamp counter width in bits.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- match_valid  input  1  one-cycle match strobe from the order book.
- match_price  input  8  match price; bit 7 is always 0 from the order book, but all 8 bits are stored.
- stats_clr  input  1  synchronous clear of statistics; the FIFO is untouched.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_ts  output  TS_W  timestamp of the head entry.
- out_price  output  8  price of the head entry.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- last_price  output  8  price of the most recent accepted-or-dropped match.
- price_delta  output  9  signed (match_price − previous last_price) for the most recent match.
- trade_count  output  16  matches seen since reset/clear; saturating.
- drop_count  output  8  matches lost to a full FIFO; saturating.
- overflow  output  1  sticky, set on any drop.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs and internal state go to 0.
  - This covers out_valid, level, pointers, ts counter, last_price, price_delta, trade_count, drop_count, overflow, and the has_last flag.
  - Reset mid-operation discards all FIFO contents.
- Timestamp:
  - A free-running TS_W counter increments every cycle and wraps from all-ones to 0.
  - A match arriving in cycle t stores the counter value of cycle t, i.e. its pre-increment value.
- FIFO:
  - Show-ahead; out_ts/out_price reflect the head combinationally from storage.
  - out_valid = (level != 0).
  - out_ts/out_price are don't-care when out_valid=0.
- Pop: occurs when out_valid && out_ready.
- Push: occurs when match_valid && (level < DEPTH || pop).
  - A full FIFO with a simultaneous pop accepts the new entry, and level stays DEPTH.
- Push into an empty FIFO becomes visible on out_valid the next cycle, so latency is 1 cycle from match_valid to out_valid.
- Drop conditions and effects:
  - A drop occurs when match_valid is high, the FIFO is full, and there is no pop.
  - drop_count increments, saturating at 255.
  - overflow is set.
  - The entry is discarded.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves level unchanged.
- Statistics update on every match_valid, whether pushed or dropped:
  - trade_count increments, saturating at 65535.
  - last_price <= match_price.
  - price_delta <= has_last ? {1'b0,match_price} − {1'b0,last_price} : 0, two's complement 9-bit.
  - has_last <= 1.
- stats_clr:
  - Clears trade_count, drop_count, overflow, price_delta, and has_last.
  - last_price is retained.
  - If stats_clr and match_valid occur in the same cycle, the clear applies first and the match is then counted: trade_count=1, and drop_count=1/overflow=1 if that match was dropped.
  - Since has_last is cleared, price_delta for that match is 0.
- No behaviour depends on circuit-breaker state; a halted book simply produces no match_valid.

Test Plan:
1. Reset, then match 0x40 at ts=5, out_ready=0:
   - Next cycle: out_valid=1, out_ts=5, out_price=0x40, level=1, trade_count=1, price_delta=0.
2. Matches 0x40 then 0x3C on consecutive cycles:
   - last_price=0x3C, price_delta=0x1FC (−4), trade_count=2.
3. out_ready=0 and 10 matches with DEPTH=8:
   - level=8, drop_count=2, overflow=1, trade_count=10.
   - Draining yields the first 8 prices in order.
4. FIFO full, match_valid and out_ready both high in the same cycle:
   - No drop; level stays 8.
   - The head advances and the new entry appears last.
5. Run the ts counter to 0xFFFF, then match:
   - Entry ts=0xFFFF; a match next cycle gets ts=0.
   - Assert rst with 3 entries queued: the next cycle gives level=0, out_valid=0, all stats 0.
6. Saturate drop_count with 300 drops:
   - drop_count=255.
   - stats_clr alone gives drop_count=0, overflow=0, and last_price unchanged.
   - stats_clr together with a match gives trade_count=1.

Source files
------------

// File: rtl/trade_tape.sv
// trade_tape: timestamped show-ahead FIFO of order-book matches with running trade statistics.
// Statistics follow every match, whether it is queued or dropped on a full FIFO.
module trade_tape #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   match_valid,
    input  logic [7:0]             match_price,
    input  logic                   stats_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TS_W-1:0]        out_ts,
    output logic [7:0]             out_price,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             last_price,
    output logic [8:0]             price_delta,
    output logic [15:0]            trade_count,
    output logic [7:0]             drop_count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [TS_W-1:0] ts_mem_q    [DEPTH];
    logic [7:0]      price_mem_q [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [7:0]      last_price_q, last_price_d;
    logic [8:0]      price_delta_q, price_delta_d;
    logic [15:0]     trade_count_q, trade_count_d;
    logic [7:0]      drop_count_q, drop_count_d;
    logic            overflow_q, overflow_d;
    logic            has_last_q, has_last_d;

    logic            pop, push, drop, full;
    logic [15:0]     trade_base;
    logic [7:0]      drop_base;
    logic            has_last_base;

    always_comb begin
        full     = (level_q == FULL_LEVEL);
        pop      = (level_q != '0) && out_ready;
        push     = match_valid && (!full || pop);
        drop     = match_valid && full && !pop;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        ts_d     = ts_q + TS_W'(1);

        // A clear in the same cycle as a match wipes the old stats first, then counts the match.
        trade_base    = stats_clr ? '0 : trade_count_q;
        drop_base     = stats_clr ? '0 : drop_count_q;
        has_last_base = stats_clr ? 1'b0 : has_last_q;

        trade_count_d = trade_base;
        drop_count_d  = drop_base;
        has_last_d    = has_last_base;
        overflow_d    = stats_clr ? 1'b0 : overflow_q;
        price_delta_d = stats_clr ? '0 : price_delta_q;
        last_price_d  = last_price_q;

        if (match_valid) begin
            trade_count_d = (trade_base == 16'hFFFF) ? trade_base : trade_base + 16'd1;
            last_price_d  = match_price;
            price_delta_d = has_last_base ? ({1'b0, match_price} - {1'b0, last_price_q}) : '0;
            has_last_d    = 1'b1;
        end

        if (drop) begin
            drop_count_d = (drop_base == 8'hFF) ? drop_base : drop_base + 8'd1;
            overflow_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            ts_q          <= '0;
            last_price_q  <= '0;
            price_delta_q <= '0;
            trade_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            has_last_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            ts_q          <= ts_d;
            last_price_q  <= last_price_d;
            price_delta_q <= price_delta_d;
            trade_count_q <= trade_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            has_last_q    <= has_last_d;
        end
    end

    // Entries carry the pre-increment timestamp of the cycle the match arrived in.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ts_mem_q[i]    <= '0;
                price_mem_q[i] <= '0;
            end
        end else if (push) begin
            ts_mem_q[wr_ptr_q]    <= ts_q;
            price_mem_q[wr_ptr_q] <= match_price;
        end
    end

    assign out_valid   = (level_q != '0);
    assign out_ts      = ts_mem_q[rd_ptr_q];
    assign out_price   = price_mem_q[rd_ptr_q];
    assign level       = level_q;
    assign last_price  = last_price_q;
    assign price_delta = price_delta_q;
    assign trade_count = trade_count_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_trade_tape.sv
// Self-checking bench for trade_tape: directed scenarios plus randomized traffic
// compared against a queue-based model of the tape and its statistics.
module tb_trade_tape;
    localparam int DEPTH = 8;
    localparam int TS_W  = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst;
    logic            match_valid;
    logic [7:0]      match_price;
    logic            stats_clr;
    logic            out_valid;
    logic            out_ready;
    logic [TS_W-1:0] out_ts;
    logic [7:0]      out_price;
    logic [LW-1:0]   level;
    logic [7:0]      last_price;
    logic [8:0]      price_delta;
    logic [15:0]     trade_count;
    logic [7:0]      drop_count;
    logic            overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TS_W-1:0] ts;
        logic [7:0]      price;
    } entry_t;

    // Reference model: the tape is a plain queue, statistics are plain integers.
    entry_t m_q[$];
    int     m_ts;
    int     m_trades;
    int     m_drops;
    int     m_last;
    int     m_delta;
    bit     m_ovf;
    bit     m_has_last;

    trade_tape #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .match_valid (match_valid),
        .match_price (match_price),
        .stats_clr   (stats_clr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ts      (out_ts),
        .out_price   (out_price),
        .level       (level),
        .last_price  (last_price),
        .price_delta (price_delta),
        .trade_count (trade_count),
        .drop_count  (drop_count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_q.delete();
        m_ts       = 0;
        m_trades   = 0;
        m_drops    = 0;
        m_last     = 0;
        m_delta    = 0;
        m_ovf      = 1'b0;
        m_has_last = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        match_valid = 1'b0;
        match_price = 8'h00;
        stats_clr   = 1'b0;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One clock: drive inputs at the falling edge, advance the model, sample 1 time unit after the rise.
    task automatic drive_cycle(input logic mv, input logic [7:0] p, input logic clr, input logic rdy);
        bit pop;
        bit accept;
        @(negedge clk);
        match_valid = mv;
        match_price = p;
        stats_clr   = clr;
        out_ready   = rdy;
        if (clr) begin
            m_trades   = 0;
            m_drops    = 0;
            m_ovf      = 1'b0;
            m_delta    = 0;
            m_has_last = 1'b0;
        end
        pop    = rdy && (m_q.size() != 0);
        accept = mv && ((m_q.size() < DEPTH) || pop);
        if (mv) begin
            m_trades   = (m_trades < 65535) ? m_trades + 1 : 65535;
            m_delta    = m_has_last ? int'(p) - m_last : 0;
            m_last     = int'(p);
            m_has_last = 1'b1;
            if (!accept) begin
                m_drops = (m_drops < 255) ? m_drops + 1 : 255;
                m_ovf   = 1'b1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (accept) m_q.push_back('{ts: TS_W'(m_ts), price: p});
        m_ts = (m_ts + 1) % (1 << TS_W);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0h want 0", out_valid); end
        checks++;
        if (level !== '0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", level); end
        checks++;
        if ({last_price, price_delta, trade_count, drop_count, overflow} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_stats got lp=%0h pd=%0h tc=%0d dc=%0d ov=%0b want all 0",
                     last_price, price_delta, trade_count, drop_count, overflow);
        end
    endtask

    task automatic test_first_match_and_delta();
        do_reset();
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h40, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_out_valid got %0b want 1", out_valid); end
        checks++;
        if (out_ts !== 16'd5) begin errors++; $display("[TB] FAIL first_out_ts got %0d want 5", out_ts); end
        checks++;
        if (out_price !== 8'h40) begin errors++; $display("[TB] FAIL first_out_price got %0h want 40", out_price); end
        checks++;
        if (level !== LW'(1)) begin errors++; $display("[TB] FAIL first_level got %0d want 1", level); end
        checks++;
        if (trade_count !== 16'd1) begin errors++; $display("[TB] FAIL first_trade_count got %0d want 1", trade_count); end
        checks++;
        if (price_delta !== 9'h000) begin errors++; $display("[TB] FAIL first_price_delta got %0h want 0", price_delta); end
        drive_cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (last_price !== 8'h3C) begin errors++; $display("[TB] FAIL delta_last_price got %0h want 3c", last_price); end
        checks++;
        if (price_delta !== 9'h1FC) begin errors++; $display("[TB] FAIL delta_price_delta got %0h want 1fc", price_delta); end
        checks++;
        if (trade_count !== 16'd2) begin errors++; $display("[TB] FAIL delta_trade_count got %0d want 2", trade_count); end
    endtask

    task automatic test_overflow_drain();
        logic [7:0] pr [10];
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pr[i] = 8'($urandom);
            drive_cycle(1'b1, pr[i], 1'b0, 1'b0);
        end
        checks++;
        if (level !== LW'(8)) begin errors++; $display("[TB] FAIL ovf_level got %0d want 8", level); end
        checks++;
        if (drop_count !== 8'd2) begin errors++; $display("[TB] FAIL ovf_drop_count got %0d want 2", drop_count); end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %0b want 1", overflow); end
        checks++;
        if (trade_count !== 16'd10) begin errors++; $display("[TB] FAIL ovf_trade_count got %0d want 10", trade_count); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({out_valid, out_price} !== {1'b1, pr[i]}) begin
                errors++;
                $display("[TB] FAIL drain_head[%0d] got v=%0b p=%0h want v=1 p=%0h", i, out_valid, out_price, pr[i]);
            end
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        end
        checks++;
        if ({out_valid, level} !== '0) begin errors++; $display("[TB] FAIL drain_empty got v=%0b lvl=%0d want 0 0", out_valid, level); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] pr [9];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pr[i] = 8'($urandom);
            drive_cycle(1'b1, pr[i], 1'b0, 1'b0);
        end
        pr[8] = 8'($urandom);
        drive_cycle(1'b1, pr[8], 1'b0, 1'b1);
        checks++;
        if (level !== LW'(8)) begin errors++; $display("[TB] FAIL fullpp_level got %0d want 8", level); end
        checks++;
        if ({drop_count, overflow} !== 9'd0) begin errors++; $display("[TB] FAIL fullpp_no_drop got dc=%0d ov=%0b want 0 0", drop_count, overflow); end
        for (int i = 1; i < 9; i++) begin
            checks++;
            if ({out_valid, out_price} !== {1'b1, pr[i]}) begin
                errors++;
                $display("[TB] FAIL fullpp_order[%0d] got v=%0b p=%0h want v=1 p=%0h", i, out_valid, out_price, pr[i]);
            end
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        end
    endtask

    task automatic test_ts_wrap_and_reset();
        do_reset();
        for (int i = 0; i < 65535; i++) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h11, 1'b0, 1'b0);
        checks++;
        if (out_ts !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_ts_ffff got %0h want ffff", out_ts); end
        drive_cycle(1'b1, 8'h22, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h33, 1'b0, 1'b1);
        checks++;
        if ({out_ts, out_price} !== {16'h0000, 8'h22}) begin
            errors++;
            $display("[TB] FAIL wrap_ts_zero got ts=%0h p=%0h want ts=0 p=22", out_ts, out_price);
        end
        drive_cycle(1'b1, 8'h44, 1'b0, 1'b0);
        checks++;
        if (level !== LW'(3)) begin errors++; $display("[TB] FAIL wrap_level got %0d want 3", level); end
        do_reset();
        checks++;
        if ({out_valid, level} !== '0) begin errors++; $display("[TB] FAIL midreset_fifo got v=%0b lvl=%0d want 0 0", out_valid, level); end
        checks++;
        if ({last_price, price_delta, trade_count, drop_count, overflow} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_stats got lp=%0h pd=%0h tc=%0d dc=%0d ov=%0b want all 0",
                     last_price, price_delta, trade_count, drop_count, overflow);
        end
    endtask

    task automatic test_drop_saturation();
        logic [7:0] lastp;
        do_reset();
        lastp = 8'h00;
        for (int i = 0; i < 308; i++) begin
            lastp = 8'($urandom);
            drive_cycle(1'b1, lastp, 1'b0, 1'b0);
        end
        checks++;
        if (drop_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_drop_count got %0d want 255", drop_count); end
        checks++;
        if (trade_count !== 16'd308) begin errors++; $display("[TB] FAIL sat_trade_count got %0d want 308", trade_count); end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({drop_count, overflow, trade_count, price_delta} !== '0) begin
            errors++;
            $display("[TB] FAIL clr_stats got dc=%0d ov=%0b tc=%0d pd=%0h want all 0", drop_count, overflow, trade_count, price_delta);
        end
        checks++;
        if (last_price !== lastp) begin errors++; $display("[TB] FAIL clr_last_price got %0h want %0h", last_price, lastp); end
        checks++;
        if (level !== LW'(8)) begin errors++; $display("[TB] FAIL clr_level got %0d want 8", level); end
        drive_cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        checks++;
        if ({trade_count, drop_count, overflow, price_delta} !== {16'd1, 8'd1, 1'b1, 9'd0}) begin
            errors++;
            $display("[TB] FAIL clr_match got tc=%0d dc=%0d ov=%0b pd=%0h want 1 1 1 0", trade_count, drop_count, overflow, price_delta);
        end
    endtask

    task automatic test_random_traffic();
        logic [LW-1:0]   exp_level;
        logic [8:0]      exp_delta;
        logic [15:0]     exp_trades;
        logic [7:0]      exp_drops;
        logic [7:0]      exp_last;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            drive_cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 31) == 0),
                        ($urandom_range(0, 2) == 0));
            exp_level  = LW'(m_q.size());
            exp_delta  = m_delta[8:0];
            exp_trades = 16'(m_trades);
            exp_drops  = 8'(m_drops);
            exp_last   = 8'(m_last);
            checks++;
            if ({out_valid, level, last_price, price_delta, trade_count, drop_count, overflow} !==
                {(m_q.size() != 0), exp_level, exp_last, exp_delta, exp_trades, exp_drops, m_ovf}) begin
                errors++;
                $display("[TB] FAIL rand_state[%0d] got v=%0b lvl=%0d lp=%0h pd=%0h tc=%0d dc=%0d ov=%0b want v=%0b lvl=%0d lp=%0h pd=%0h tc=%0d dc=%0d ov=%0b",
                         n, out_valid, level, last_price, price_delta, trade_count, drop_count, overflow,
                         (m_q.size() != 0), exp_level, exp_last, exp_delta, exp_trades, exp_drops, m_ovf);
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({out_ts, out_price} !== {m_q[0].ts, m_q[0].price}) begin
                    errors++;
                    $display("[TB] FAIL rand_head[%0d] got ts=%0h p=%0h want ts=%0h p=%0h",
                             n, out_ts, out_price, m_q[0].ts, m_q[0].price);
                end
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        match_valid = 1'b0;
        match_price = 8'h00;
        stats_clr   = 1'b0;
        out_ready   = 1'b0;
        model_clear();
        test_reset();
        test_first_match_and_delta();
        test_overflow_drain();
        test_full_push_pop();
        test_drop_saturation();
        test_random_traffic();
        test_ts_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
